// File: rtl/control_multi_if.sv
// Bus between the multi-cycle control FSM and the shared datapath.
// Signals:
//   opcode, mem_ready         datapath -> control (IR[31:26], memory done)
//   PCWrite .. PCSource       control -> datapath (per-step control lines)
//   state                     current FSM state, for debug
//   illegal_op, instr_cnt     sticky undefined-opcode flag, retired count
// Modports: master = control unit, slave = datapath / observer.
interface control_multi_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_cnt
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state, illegal_op, instr_cnt
    );
endinterface

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared
// memory, ALU, IR, PC and register file. Also keeps a sticky illegal-opcode
// flag and a retired-instruction counter.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  control_multi_if.master (opcode/mem_ready in, control lines out)
// Build option:
//   CTRL_MULTI_MEM_HANDSHAKE_EN  when defined, IF/MRD/MWR wait for mem_ready
//   and IRWrite/PCWrite in IF fire only in the ready cycle; when undefined,
//   mem_ready is ignored and those states last one cycle.
module control_multi #(
    parameter int unsigned CNT_W  = 32,
    parameter logic [5:0]  OP_R   = 6'd0,
    parameter logic [5:0]  OP_LW  = 6'd35,
    parameter logic [5:0]  OP_SW  = 6'd43,
    parameter logic [5:0]  OP_BEQ = 6'd4,
    parameter logic [5:0]  OP_J   = 6'd2,
    parameter logic [5:0]  OP_NOP = 6'd63
) (
    input  logic             clk,
    input  logic             rst,
    control_multi_if.master  bus
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_IF   = 4'd1,
        S_ID   = 4'd2,
        S_MADR = 4'd3,
        S_MRD  = 4'd4,
        S_MWB  = 4'd5,
        S_MWR  = 4'd6,
        S_EXE  = 4'd7,
        S_RWB  = 4'd8,
        S_BR   = 4'd9,
        S_JMP  = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic             is_lw_q, is_lw_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_c;
    logic             ready_c;

    // Registered control lines, decoded from the next state.
    logic       fetch_q, fetch_d;
    logic       pc_write_q, pc_write_d;
    logic       pc_write_cond_q, pc_write_cond_d;
    logic       iord_q, iord_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_dst_q, reg_dst_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [1:0] pc_source_q, pc_source_d;

`ifdef CTRL_MULTI_MEM_HANDSHAKE_EN
    assign ready_c = bus.mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready;
    assign ready_c          = 1'b1;
`endif

    // Next state, sticky flag, retire strobe and next control lines.
    always_comb begin
        state_d         = state_q;
        is_lw_d         = is_lw_q;
        ill_d           = ill_q;
        retire_c        = 1'b0;
        fetch_d         = 1'b0;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        iord_d          = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_dst_d       = 1'b0;
        reg_write_d     = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        alu_op_d        = 2'b00;
        pc_source_d     = 2'b00;

        case (state_q)
            S_RST:  state_d = S_IF;
            S_IF:   if (ready_c) state_d = S_ID;
            S_ID: begin
                case (bus.opcode)
                    OP_R:   state_d = S_EXE;
                    OP_LW: begin
                        state_d = S_MADR;
                        is_lw_d = 1'b1;
                    end
                    OP_SW: begin
                        state_d = S_MADR;
                        is_lw_d = 1'b0;
                    end
                    OP_BEQ: state_d = S_BR;
                    OP_J:   state_d = S_JMP;
                    OP_NOP: begin
                        state_d  = S_IF;
                        retire_c = 1'b1;
                    end
                    default: begin
                        state_d = S_IF;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            // lw/sw choice was latched from the opcode in ID.
            S_MADR: state_d = is_lw_q ? S_MRD : S_MWR;
            S_MRD:  if (ready_c) state_d = S_MWB;
            S_MWR: begin
                if (ready_c) begin
                    state_d  = S_IF;
                    retire_c = 1'b1;
                end
            end
            S_EXE:  state_d = S_RWB;
            S_MWB, S_RWB, S_BR, S_JMP: begin
                state_d  = S_IF;
                retire_c = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // Moore decode of the state being entered.
        case (state_d)
            S_IF: begin
                fetch_d     = 1'b1;
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_ID:   alu_src_b_d = 2'b11;
            S_MADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MRD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MWR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            S_EXE: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_RWB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
            end
            S_BR: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
            end
            S_JMP: begin
                pc_write_d  = 1'b1;
                pc_source_d = 2'b10;
            end
            default: ;
        endcase
    end

    assign cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;

    // State, status and control registers; reset clears every control line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_RST;
            is_lw_q         <= 1'b0;
            ill_q           <= 1'b0;
            cnt_q           <= '0;
            fetch_q         <= 1'b0;
            pc_write_q      <= 1'b0;
            pc_write_cond_q <= 1'b0;
            iord_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_dst_q       <= 1'b0;
            reg_write_q     <= 1'b0;
            alu_src_a_q     <= 1'b0;
            alu_src_b_q     <= 2'b00;
            alu_op_q        <= 2'b00;
            pc_source_q     <= 2'b00;
        end else begin
            state_q         <= state_d;
            is_lw_q         <= is_lw_d;
            ill_q           <= ill_d;
            cnt_q           <= cnt_d;
            fetch_q         <= fetch_d;
            pc_write_q      <= pc_write_d;
            pc_write_cond_q <= pc_write_cond_d;
            iord_q          <= iord_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_dst_q       <= reg_dst_d;
            reg_write_q     <= reg_write_d;
            alu_src_a_q     <= alu_src_a_d;
            alu_src_b_q     <= alu_src_b_d;
            alu_op_q        <= alu_op_d;
            pc_source_q     <= pc_source_d;
        end
    end

    // Fetch strobes are qualified by memory readiness (always 1 without the wait).
    assign bus.IRWrite     = fetch_q & ready_c;
    assign bus.PCWrite     = pc_write_q | (fetch_q & ready_c);
    assign bus.PCWriteCond = pc_write_cond_q;
    assign bus.IorD        = iord_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;
    assign bus.MemtoReg    = mem_to_reg_q;
    assign bus.RegDst      = reg_dst_q;
    assign bus.RegWrite    = reg_write_q;
    assign bus.ALUSrcA     = alu_src_a_q;
    assign bus.ALUSrcB     = alu_src_b_q;
    assign bus.ALUOp       = alu_op_q;
    assign bus.PCSource    = pc_source_q;
    assign bus.state       = 4'(state_q);
    assign bus.illegal_op  = ill_q;
    assign bus.instr_cnt   = cnt_q;

endmodule

// File: tb/tb_control_multi.sv
// Directed bench for control_multi: each instruction pushes its expected
// per-cycle state/control/status records into a queue, which is then drained
// cycle by cycle while driving opcode/mem_ready and comparing the DUT.
module tb_control_multi;

    localparam int unsigned CNT_W = 4;
`ifdef CTRL_MULTI_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct {
        logic [5:0]       op;
        logic             rdy;
        logic [3:0]       st;
        logic [15:0]      ctrl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    logic clk;
    logic rst;
    control_multi_if #(.CNT_W(CNT_W)) bus ();

    control_multi #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rec_t             q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               step  = 0;
    logic             m_ill = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    // Expected control lines for a state, packed in a fixed order.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd1: begin
                mr = 1'b1; sb = 2'b01;
                irw = HS ? rdy : 1'b1;
                pcw = HS ? rdy : 1'b1;
            end
            4'd2: sb = 2'b11;
            4'd3: begin sa = 1'b1; sb = 2'b10; end
            4'd4: begin mr = 1'b1; iord = 1'b1; end
            4'd5: begin rw = 1'b1; m2r = 1'b1; end
            4'd6: begin mw = 1'b1; iord = 1'b1; end
            4'd7: begin sa = 1'b1; aop = 2'b10; end
            4'd8: begin rw = 1'b1; rd = 1'b1; end
            4'd9: begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            4'd10: begin pcw = 1'b1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
        end
    endtask

    task automatic chk_rec(input rec_t r);
        chk("state",   32'(bus.state),      32'(r.st));
        chk("ctrl",    32'(obs_ctrl()),     32'(r.ctrl));
        chk("illegal", 32'(bus.illegal_op), 32'(r.ill));
        chk("cnt",     32'(bus.instr_cnt),  32'(r.cnt));
    endtask

    task automatic push(input logic [5:0] op, input logic [3:0] st, input logic rdy);
        rec_t r;
        r.op = op; r.rdy = rdy; r.st = st;
        r.ctrl = exp_ctrl(st, rdy);
        r.ill = m_ill; r.cnt = m_cnt;
        q.push_back(r);
    endtask

    // Memory-waiting state: waits then a ready cycle, or one cycle without handshake.
    task automatic push_mem(input logic [5:0] op, input logic [3:0] st, input int waits);
        if (HS) begin
            for (int i = 0; i < waits; i++) push(op, st, 1'b0);
            push(op, st, 1'b1);
        end else begin
            push(op, st, (waits > 0) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int if_wait, input int mem_wait);
        bit legal;
        legal = 1'b1;
        push_mem(op, 4'd1, if_wait);
        push(op, 4'd2, 1'b1);
        case (op)
            6'd0:  begin push(op, 4'd7, 1'b1); push(op, 4'd8, 1'b1); end
            6'd35: begin push(op, 4'd3, 1'b1); push_mem(op, 4'd4, mem_wait); push(op, 4'd5, 1'b1); end
            6'd43: begin push(op, 4'd3, 1'b1); push_mem(op, 4'd6, mem_wait); end
            6'd4:  push(op, 4'd9, 1'b1);
            6'd2:  push(op, 4'd10, 1'b1);
            6'd63: ;
            default: legal = 1'b0;
        endcase
        if (legal) m_cnt = m_cnt + CNT_W'(1);
        else       m_ill = 1'b1;
    endtask

    task automatic drain();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            bus.opcode    = r.op;
            bus.mem_ready = r.rdy;
            #1;
            step++;
            chk_rec(r);
        end
    endtask

    // Reset-state record (all controls 0, status cleared).
    task automatic chk_reset_now();
        rec_t r;
        r.op = bus.opcode; r.rdy = bus.mem_ready; r.st = 4'd0;
        r.ctrl = 16'd0; r.ill = 1'b0; r.cnt = '0;
        step++;
        chk_rec(r);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        m_ill = 1'b0;
        m_cnt = '0;
        push(6'd0, 4'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1 chk_reset_now();
        release_reset();

        // R-type, then lw/sw, then beq/j/nop.
        gen_instr(6'd0, 0, 0);
        gen_instr(6'd35, 0, 0);
        gen_instr(6'd43, 0, 0);
        gen_instr(6'd4, 0, 0);
        gen_instr(6'd2, 0, 0);
        gen_instr(6'd63, 0, 0);
        drain();

        // Undefined opcode, then three R-types with the sticky flag held.
        gen_instr(6'd5, 0, 0);
        for (int i = 0; i < 3; i++) gen_instr(6'd0, 0, 0);
        drain();

        // lw with memory stalls in IF and MRD, plus an sw stalled in MWR.
        gen_instr(6'd35, 3, 2);
        gen_instr(6'd43, 0, 1);
        drain();

        // Reset asserted while in RWB: controls drop without a clock edge.
        gen_instr(6'd0, 0, 0);
        drain();
        rst = 1'b1;
        #1 chk_reset_now();
        release_reset();

        // Sixteen R-types wrap the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) gen_instr(6'd0, 0, 0);
        push(6'd0, 4'd1, 1'b1);
        drain();
        chk("wrap", 32'(bus.instr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_multi.md
Name: control_multi

Overview:
- Multi-cycle MIPS control FSM. It sequences a shared datapath (one memory, one ALU, IR, PC, register file) across IF/ID/EX/MEM/WB steps.
- It replaces the single-cycle decoder in the multi-cycle build.
- It decodes the same opcode set as the single-cycle control unit.
- It adds a memory wait handshake, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- OP_R, 6'd0: R-format opcode.
- OP_LW, 6'd35: lw opcode.
- OP_SW, 6'd43: sw opcode.
- OP_BEQ, 6'd4: beq opcode.
- OP_J, 6'd2: j opcode.
- OP_NOP, 6'd63: nop opcode.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled only in state ID.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero.
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  write-back select: 1=MDR.
- RegDst  out  1  destination select: 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A.
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- ALUOp  out  2  to ALU control: 00 add, 01 sub, 10 funct.
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target.
- state  out  4  current state, for debug.
- illegal_op  out  1  sticky flag: undefined opcode seen.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: rst high forces state=RST(0), illegal_op=0, instr_cnt=0.
  - In RST, every output is 0.
  - RST always moves to IF on the next clock after rst deasserts.
- Outputs are Moore, decoded from state. Every control not listed for a state is driven 0; never x.
- State encoding and per-state outputs:
  - RST=0: all outputs 0.
  - IF=1: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 (gated, see handshake).
  - ID=2: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MADR=3: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MRD=4: MemRead=1, IorD=1.
  - MWB=5: RegWrite=1, MemtoReg=1, RegDst=0.
  - MWR=6: MemWrite=1, IorD=1.
  - EXE=7: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB=8: RegWrite=1, RegDst=1.
  - BR=9: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JMP=10: PCWrite=1, PCSource=10.
  - Codes 11-15 are unreachable; if entered, go to IF next cycle with all outputs 0.
- Transitions:
  - IF->ID.
  - ID: R->EXE, LW/SW->MADR, BEQ->BR, J->JMP, NOP->IF, any other opcode->IF with illegal_op set to 1.
  - MADR: ->MRD if LW, ->MWR if SW (opcode still held in IR).
  - MRD->MWB.
  - EXE->RWB.
  - MWB, MWR, RWB, BR, JMP->IF.
- Cycle counts: R=4, LW=5, SW=4, BEQ=3, J=3, NOP=2, illegal=2.
- Memory handshake (under the macro below):
  - IF, MRD and MWR hold while mem_ready=0.
  - In IF, IRWrite and PCWrite are asserted only when mem_ready=1.
  - MemRead/MemWrite stay high for the whole wait.
- illegal_op is sticky and is cleared only by rst.
- instr_cnt:
  - Increments by 1 on the clock edge leaving MWB, MWR, RWB, BR or JMP, and leaving ID for a NOP.
  - Does not increment for illegal opcodes.
  - Wraps modulo 2^CNT_W.
- rst asserted mid-instruction: immediate return to RST. No partial write-enable survives past the reset edge.

Optional Feature:
- Macro: CTRL_MULTI_MEM_HANDSHAKE_EN.
- Defined: the mem_ready wait behaviour above applies.
- Undefined: mem_ready is ignored (port still present). IF, MRD and MWR each last exactly one cycle, and IRWrite/PCWrite are high throughout IF.

Test Plan:
- Reset and R-type: rst pulse, then opcode=0, mem_ready=1.
  - Required: states 0,1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8; instr_cnt=1.
- LW then SW, mem_ready=1:
  - LW required: states 1,2,3,4,5 with MemtoReg=1 in 5.
  - SW required: states 1,2,3,6 with MemWrite=1, IorD=1 in 6.
  - instr_cnt=2.
- BEQ, J, NOP:
  - BEQ: 3 cycles, PCWriteCond=1, PCSource=01 in state 9.
  - J: 3 cycles, PCWrite=1, PCSource=10 in state 10.
  - NOP: 2 cycles.
  - instr_cnt=3.
- Illegal opcode 6'd5 in ID:
  - Required: next state IF, illegal_op=1 and stays 1 over 3 further R-types, instr_cnt unchanged by the illegal instruction.
- Handshake (macro defined): LW with mem_ready=0 for 3 cycles in IF and 2 cycles in MRD.
  - Required: IRWrite and PCWrite high only in the ready cycle; total of 10 cycles.
  - Same stimulus with macro undefined: 5 cycles.
- rst asserted in state 8 (RWB), plus wrap check:
  - Required: RegWrite drops in the same cycle, state=0, counters cleared.
  - With CNT_W=4, 16 R-types wrap instr_cnt to 0.
